gtb_reconf_ctrl: RTL and testbench
==================================

# gtb_reconf_ctrl

Time-set/reconfiguration controller for the global time base counter. It arbitrates round-robin between NUM_REQ requesters that want to load a new global time value. It pre-loads the winner's value into the counter with SetTimeVal/NewTimeVal, then holds off until the counter reaches the requested activation instant and issues a single-cycle ReconfInst. The block sits beside the global time base and drives the three counter control inputs that are otherwise tied off.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- TIME_W, 64: width of time values and TimeCnt.
- WDOG_CYC, 4096: watchdog limit in clk cycles; used only with GTB_CTRL_WDOG_EN.
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- TimeCnt  in  TIME_W  current global time from the counter.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid & ready.
- req_newval  in  NUM_REQ*TIME_W  new time value; slice i belongs to requester i.
- req_act  in  NUM_REQ*TIME_W  activation instant in TimeCnt units; slice i belongs to requester i.
- req_ack  out  NUM_REQ  one-cycle pulse: reconfiguration committed.
- req_err  out  NUM_REQ  one-cycle pulse: request rejected or aborted.
- SetTimeVal  out  1  one-cycle pulse that loads NewTimeVal into the counter's pending register.
- NewTimeVal  out  TIME_W  latched new value; stable from LOAD until the next capture.
- ReconfInst  out  1  one-cycle pulse that makes the counter switch to the pending value.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: req_ready is the one-hot round-robin winner among the asserted req_valid bits, searching upward from the requester after the last granted one (wrapping at NUM_REQ-1). When no request is asserted, req_ready = 0. On a transfer, latch the granted index, newval and act.
    - If the latched act <= TimeCnt (unsigned) in the capture cycle, go to ERR.
    - Otherwise go to LOAD.
  - LOAD: SetTimeVal = 1 and NewTimeVal = latched newval; go to WAIT.
  - WAIT: when TimeCnt >= act (unsigned), go to COMMIT.
  - COMMIT: ReconfInst = 1; go to DONE.
  - DONE: req_ack[granted] = 1; go to IDLE.
  - ERR: req_err[granted] = 1; go to IDLE. SetTimeVal and ReconfInst are not asserted.
- The round-robin pointer advances to the granted index on every transfer, whether the request succeeds or errors.
- The comparison is full-width unsigned. Counter wrap-around is not handled; an act value already passed counts as late.
- The block does not check the counter after ReconfInst; the counter applies the new value.
- Requests not granted keep req_valid asserted and are served one at a time. There is no queueing beyond the single latched transaction.
- Reset mid-operation: the FSM returns to IDLE, the pointer resets to 0, the pending transaction is dropped, and no ack or err is issued.

## Timing
- Reset values: req_ready, req_ack, req_err, SetTimeVal, ReconfInst and busy = 0; NewTimeVal = 0.
- All outputs except req_ready are registered state decodes. req_ready is combinational from req_valid and the pointer, and only in IDLE.
- Capture in cycle C; SetTimeVal in C+1; earliest ReconfInst in C+3, when TimeCnt >= act at C+2.
- ReconfInst is asserted in the cycle after the first cycle in which TimeCnt >= act.
- ack is asserted one cycle after ReconfInst. The next grant is possible in the cycle after ack.
- Late request: err is asserted in C+1. The next grant is possible in C+2.
- SetTimeVal and ReconfInst each pulse exactly once per successful transaction.

## Configuration
- GTB_CTRL_WDOG_EN defined:
  - A cycle counter (width clog2(WDOG_CYC+1)) clears on entry to WAIT and increments every cycle in WAIT.
  - When it reaches WDOG_CYC without the instant being reached, go to ERR: req_err pulses and no ReconfInst is issued.
  - The pending value loaded by SetTimeVal is left in the counter and is overwritten by the next LOAD.
- GTB_CTRL_WDOG_EN undefined: WAIT persists indefinitely; no watchdog logic is present.

## Structure
- Package gtb_ctrl_pkg holds:
  - the FSM state enum (IDLE, LOAD, WAIT, COMMIT, DONE, ERR);
  - the TIME_W default constant.
- One sub-module: gtb_rr_arbiter (NUM_REQ, req vector and pointer in, one-hot grant and index out), combinational.
- Everything else lives in gtb_reconf_ctrl.

## Test plan
- Reset, then idle with no requests -> all outputs 0, busy = 0, NewTimeVal = 0.
- Requester 1, newval = 0x1000, act = TimeCnt+10, counter free-running +1/clk -> SetTimeVal one cycle after capture with NewTimeVal = 0x1000; ReconfInst in the cycle after TimeCnt == act; req_ack[1] one cycle later; exactly one pulse of each.
- Requester 2, act = TimeCnt-1 -> req_err[2] in C+1; no SetTimeVal or ReconfInst; busy for 1 cycle.
- Requesters 0, 1 and 3 assert together and hold until granted, each with act = TimeCnt+5 -> grants in order 0, 1, 3. A following new request from 0 together with 3 grants 0 before 3.
- Assert reset_n low during WAIT -> outputs 0 immediately, no ack or err; after release a new request completes normally.
- With GTB_CTRL_WDOG_EN and WDOG_CYC = 16, act = TimeCnt+100 -> req_err after 16 WAIT cycles with no ReconfInst. Without the macro, the same stimulus gives ReconfInst at the instant.

Source files
------------

// File: rtl/gtb_ctrl_pkg.sv
// Shared types for the global time base reconfiguration controller.
// Holds the controller FSM encoding and the default time width.
package gtb_ctrl_pkg;

  localparam int TIME_W_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    COMMIT,
    DONE,
    ERR
  } ctrl_state_t;

endpackage

// File: rtl/gtb_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request strictly after ptr, wrapping.
// Combinational, zero latency; grant is all-zero when no request is asserted.
module gtb_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    // k runs 1..NUM_REQ so the last-granted requester has lowest priority
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

endmodule

// File: rtl/gtb_reconf_ctrl.sv
// Time-set controller: grants one requester, preloads its value, fires ReconfInst at the instant.
// SetTimeVal 1 cycle after capture; one transaction at a time; optional watchdog via GTB_CTRL_WDOG_EN.
module gtb_reconf_ctrl
  import gtb_ctrl_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TIME_W   = TIME_W_DEF,
  parameter int WDOG_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [TIME_W-1:0]         TimeCnt,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*TIME_W-1:0] req_newval,
  input  logic [NUM_REQ*TIME_W-1:0] req_act,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_err,
  output logic                      SetTimeVal,
  output logic [TIME_W-1:0]         NewTimeVal,
  output logic                      ReconfInst,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYC < 1) begin : g_cfg_check
    $error("gtb_reconf_ctrl: unsupported NUM_REQ or WDOG_CYC");
  end

  ctrl_state_t        state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] grant;
  logic [TIME_W-1:0]  act_q;
  logic [TIME_W-1:0]  cap_newval;
  logic [TIME_W-1:0]  cap_act;
  logic               xfer;
  logic               wdog_expired;

  gtb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  assign req_ready  = (state == IDLE) ? grant : '0;
  assign xfer       = |(req_valid & req_ready);
  assign cap_newval = req_newval[int'(gnt_idx)*TIME_W +: TIME_W];
  assign cap_act    = req_act[int'(gnt_idx)*TIME_W +: TIME_W];

`ifdef GTB_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);

  logic [WD_W-1:0] wdog_cnt;

  // Held at zero outside WAIT, so it restarts on every entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      wdog_cnt <= '0;
    else if (state != WAIT)
      wdog_cnt <= '0;
    else
      wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign wdog_expired = (state == WAIT) && (wdog_cnt == WD_W'(WDOG_CYC - 1));
`else
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cur_idx    <= '0;
      act_q      <= '0;
      NewTimeVal <= '0;
      SetTimeVal <= 1'b0;
      ReconfInst <= 1'b0;
      req_ack    <= '0;
      req_err    <= '0;
      busy       <= 1'b0;
    end else begin
      SetTimeVal <= 1'b0;
      ReconfInst <= 1'b0;
      req_ack    <= '0;
      req_err    <= '0;
      case (state)
        IDLE: begin
          if (xfer) begin
            ptr     <= gnt_idx;
            cur_idx <= gnt_idx;
            act_q   <= cap_act;
            busy    <= 1'b1;
            // An instant equal to the current count is already too late to hit.
            if (cap_act <= TimeCnt) begin
              state            <= ERR;
              req_err[gnt_idx] <= 1'b1;
            end else begin
              state      <= LOAD;
              SetTimeVal <= 1'b1;
              NewTimeVal <= cap_newval;
            end
          end
        end
        LOAD: state <= WAIT;
        WAIT: begin
          if (TimeCnt >= act_q) begin
            state      <= COMMIT;
            ReconfInst <= 1'b1;
          end else if (wdog_expired) begin
            state            <= ERR;
            req_err[cur_idx] <= 1'b1;
          end
        end
        COMMIT: begin
          state            <= DONE;
          req_ack[cur_idx] <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gtb_reconf_ctrl.sv
// Scoreboard bench for gtb_reconf_ctrl: stimulus queues expected events, a monitor checks them.
module tb_gtb_reconf_ctrl;

  localparam int NUM_REQ  = 4;
  localparam int TIME_W   = 64;
  localparam int WDOG_CYC = 16;

  localparam int K_GRANT  = 0;
  localparam int K_SET    = 1;
  localparam int K_RECONF = 2;
  localparam int K_ACK    = 3;
  localparam int K_ERR    = 4;

  typedef struct {
    int          kind;
    int          idx;
    logic [63:0] val;
    int          off;
  } exp_t;

  exp_t exp_q[$];

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [TIME_W-1:0]         TimeCnt = 64'h100;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*TIME_W-1:0] req_newval;
  logic [NUM_REQ*TIME_W-1:0] req_act;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        req_err;
  logic                      SetTimeVal;
  logic [TIME_W-1:0]         NewTimeVal;
  logic                      ReconfInst;
  logic                      busy;

  logic [TIME_W-1:0] nv [NUM_REQ];
  longint            act_off [NUM_REQ];

  int n_chk   = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cap_cyc = 0;
  bit chk_idle = 1'b0;

  gtb_reconf_ctrl #(.NUM_REQ(NUM_REQ), .TIME_W(TIME_W), .WDOG_CYC(WDOG_CYC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .TimeCnt    (TimeCnt),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_newval (req_newval),
    .req_act    (req_act),
    .req_ack    (req_ack),
    .req_err    (req_err),
    .SetTimeVal (SetTimeVal),
    .NewTimeVal (NewTimeVal),
    .ReconfInst (ReconfInst),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Free-running global time base, +1 per clock, independent of the controller reset.
  always @(posedge clk) TimeCnt <= TimeCnt + 64'd1;

  // Activation instants track the live counter so a waiting requester keeps its relative offset.
  always_comb begin
    req_newval = '0;
    req_act    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_newval[i*TIME_W +: TIME_W] = nv[i];
      req_act[i*TIME_W +: TIME_W]    = TimeCnt + TIME_W'(act_off[i]);
    end
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int idx_of(logic [NUM_REQ-1:0] v);
    int r = -1;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (v[i]) r = i;
    return r;
  endfunction

  task automatic got_evt(int kind, int idx, logic [63:0] val);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d idx %0d, expected none (cycle %0d)", kind, idx, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("evt_kind", 64'(kind), 64'(e.kind));
    check("evt_idx", 64'(idx), 64'(e.idx));
    check("evt_val", val, e.val);
    check("evt_cycle_offset", 64'(cyc - cap_cyc), 64'(e.off));
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (chk_idle) begin
          check("busy_after_done", 64'(busy), 64'd0);
          chk_idle = 1'b0;
        end
        if (|(req_valid & req_ready)) begin
          check("grant_onehot", 64'($onehot(req_valid & req_ready)), 64'd1);
          check("busy_at_capture", 64'(busy), 64'd0);
          cap_cyc = cyc;
          got_evt(K_GRANT, idx_of(req_valid & req_ready), 64'd0);
        end
        if (SetTimeVal) got_evt(K_SET, 0, NewTimeVal);
        if (ReconfInst) got_evt(K_RECONF, 0, 64'd0);
        if (|req_ack) begin
          check("ack_busy", 64'(busy), 64'd1);
          got_evt(K_ACK, idx_of(req_ack), 64'd0);
          chk_idle = 1'b1;
        end
        if (|req_err) begin
          check("err_busy", 64'(busy), 64'd1);
          got_evt(K_ERR, idx_of(req_err), 64'd0);
          chk_idle = 1'b1;
        end
      end
    end
  end

  task automatic push(int kind, int idx, logic [63:0] val, int off);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    e.off  = off;
    exp_q.push_back(e);
  endtask

  // Successful transaction: first WAIT cycle is capture+2, ReconfInst follows the first hit.
  task automatic expect_ok(int idx, logic [63:0] v, int off);
    int hit = (off < 2) ? 2 : off;
    push(K_GRANT, idx, 64'd0, 0);
    push(K_SET, 0, v, 1);
    push(K_RECONF, 0, 64'd0, hit + 1);
    push(K_ACK, idx, 64'd0, hit + 2);
  endtask

  task automatic expect_err(int idx);
    push(K_GRANT, idx, 64'd0, 0);
    push(K_ERR, idx, 64'd0, 1);
  endtask

  task automatic run_reqs(logic [NUM_REQ-1:0] mask);
    logic [NUM_REQ-1:0] x;
    int budget = 2000;
    req_valid = mask;
    while (req_valid != '0 && budget > 0) begin
      @(negedge clk);
      x = req_valid & req_ready;
      @(posedge clk);
      #1 req_valid = req_valid & ~x;
      budget--;
    end
    if (req_valid != '0) begin
      n_chk++;
      n_fail++;
      $display("FAIL grant_timeout: still waiting 0x%0h, expected 0x0", req_valid);
      req_valid = '0;
    end
  endtask

  task automatic drain();
    int b = 400;
    while (exp_q.size() != 0 && b > 0) begin
      @(posedge clk);
      b--;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_ack"}, 64'(req_ack), 64'd0);
    check({tag, "_err"}, 64'(req_err), 64'd0);
    check({tag, "_set"}, 64'(SetTimeVal), 64'd0);
    check({tag, "_reconf"}, 64'(ReconfInst), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_newval"}, NewTimeVal, 64'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      nv[i]      = '0;
      act_off[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check_quiet("rst");
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready", 64'(req_ready), 64'd0);
    check_quiet("idle");

    // Single successful request from requester 1
    nv[1] = 64'h1000; act_off[1] = 10;
    expect_ok(1, 64'h1000, 10);
    run_reqs(4'b0010);
    drain();

    // Late requests: instant already passed, then instant equal to the count
    nv[2] = 64'h2222; act_off[2] = -1;
    expect_err(2);
    run_reqs(4'b0100);
    drain();
    check("newval_kept_after_err", NewTimeVal, 64'h1000);
    act_off[2] = 0;
    expect_err(2);
    run_reqs(4'b0100);
    drain();

    // Earliest possible commit
    nv[3] = 64'h3333; act_off[3] = 2;
    expect_ok(3, 64'h3333, 2);
    run_reqs(4'b1000);
    drain();

    // Contention after 3 was last granted: order 0, 1, 3
    nv[0] = 64'hA0; nv[1] = 64'hA1; nv[3] = 64'hA3;
    act_off[0] = 5; act_off[1] = 5; act_off[3] = 5;
    expect_ok(0, 64'hA0, 5);
    expect_ok(1, 64'hA1, 5);
    expect_ok(3, 64'hA3, 5);
    run_reqs(4'b1011);
    drain();

    // 3 was last granted, so 0 wins over 3
    nv[0] = 64'hB0; nv[3] = 64'hB3;
    expect_ok(0, 64'hB0, 5);
    expect_ok(3, 64'hB3, 5);
    run_reqs(4'b1001);
    drain();

    // Reset while waiting for the instant: transaction dropped silently
    nv[1] = 64'hC1; act_off[1] = 50;
    push(K_GRANT, 1, 64'd0, 0);
    push(K_SET, 0, 64'hC1, 1);
    run_reqs(4'b0010);
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_events_seen", 64'(exp_q.size()), 64'd0);
    reset_n = 1'b0;
    #1;
    check_quiet("midrst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Pointer back at 0 after reset: 1 is served before 0
    nv[0] = 64'hD0; nv[1] = 64'hD1;
    act_off[0] = 4; act_off[1] = 4;
    expect_ok(1, 64'hD1, 4);
    expect_ok(0, 64'hD0, 4);
    run_reqs(4'b0011);
    drain();

    // Far instant: watchdog abort when enabled, otherwise commit at the instant
    nv[2] = 64'hE2; act_off[2] = 100;
`ifdef GTB_CTRL_WDOG_EN
    push(K_GRANT, 2, 64'd0, 0);
    push(K_SET, 0, 64'hE2, 1);
    push(K_ERR, 2, 64'd0, 2 + WDOG_CYC);
`else
    expect_ok(2, 64'hE2, 100);
`endif
    run_reqs(4'b0100);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
